// File: rtl/iir_det_pkg.sv
// iir_det_pkg: shared widths, default thresholds and detector FSM states
package iir_det_pkg;
    localparam int XW = 11;
    localparam int MW = 10;
    localparam int WIN_LOG2_DEF = 4;
    localparam int HOLD_DEF = 2;
    localparam logic [MW-1:0] TH_ON_DEF = 10'd256;
    localparam logic [MW-1:0] TH_OFF_DEF = 10'd128;
    typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, RELEASING} det_state_t;
endpackage

// File: rtl/window_accumulator.sv
// window_accumulator: saturating rectifier plus fixed-window mean of |x|
module window_accumulator
    import iir_det_pkg::*;
#(
    parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [XW-1:0] x,
    output logic [MW-1:0] mean,
    output logic          mean_valid,
    output logic          win_end,
    output logic [MW-1:0] m
);
    localparam int AW = MW + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] ONE = 1;
    logic [XW-1:0] neg;
    logic [MW-1:0] a;
    logic [AW-1:0] acc, sum;
    logic [WIN_LOG2-1:0] cnt;
    // -1024 has no positive Q1.10 counterpart, so it clips to full scale
    always_comb begin
        neg = -x;
        a = x == {1'b1, {(XW-1){1'b0}}} ? '1 : x[XW-1] ? neg[MW-1:0] : x[MW-1:0];
        sum = acc + {{WIN_LOG2{1'b0}}, a};
        m = sum[WIN_LOG2 +: MW];
        win_end = in_valid && &cnt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            mean <= '0;
            mean_valid <= 1'b0;
        end else begin
            mean_valid <= win_end;
            if (in_valid) begin
                cnt <= cnt + ONE;
                acc <= win_end ? '0 : sum;
            end
            if (win_end) mean <= m;
        end
    end
endmodule

// File: rtl/iir_energy_detector.sv
// iir_energy_detector: windowed |x| mean with debounced hysteresis tone detect
module iir_energy_detector
    import iir_det_pkg::*;
#(
    parameter int            WIN_LOG2 = WIN_LOG2_DEF,
    parameter logic [MW-1:0] TH_ON    = TH_ON_DEF,
    parameter logic [MW-1:0] TH_OFF   = TH_OFF_DEF,
    parameter int            HOLD     = HOLD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [XW-1:0] x,
    output logic [MW-1:0] mean,
    output logic          mean_valid,
    output logic          detect,
    output logic          detect_rise,
    output logic          detect_fall
);
    localparam logic [3:0] HOLD_N = HOLD[3:0];
    logic win_end, ndet;
    logic [MW-1:0] m;
    logic [3:0] hcnt, nhcnt, hinc;
    det_state_t state, nstate;

    window_accumulator #(.WIN_LOG2(WIN_LOG2)) u_win (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x),
        .mean(mean), .mean_valid(mean_valid), .win_end(win_end), .m(m)
    );

    // hcnt counts consecutive qualifying windows while a state change is pending
    always_comb begin
        nstate = state;
        nhcnt = hcnt;
        hinc = hcnt + 4'd1;
        if (win_end)
            case (state)
                IDLE: if (m >= TH_ON) begin
                    nstate = HOLD_N == 4'd1 ? ACTIVE : ARMING;
                    nhcnt = HOLD_N == 4'd1 ? 4'd0 : 4'd1;
                end
                ARMING: begin
                    nstate = m < TH_ON ? IDLE : hinc == HOLD_N ? ACTIVE : ARMING;
                    nhcnt = m < TH_ON || hinc == HOLD_N ? 4'd0 : hinc;
                end
                ACTIVE: if (m < TH_OFF) begin
                    nstate = HOLD_N == 4'd1 ? IDLE : RELEASING;
                    nhcnt = HOLD_N == 4'd1 ? 4'd0 : 4'd1;
                end
                RELEASING: begin
                    nstate = m >= TH_OFF ? ACTIVE : hinc == HOLD_N ? IDLE : RELEASING;
                    nhcnt = m >= TH_OFF || hinc == HOLD_N ? 4'd0 : hinc;
                end
            endcase
        ndet = nstate == ACTIVE || nstate == RELEASING;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hcnt <= '0;
            detect <= 1'b0;
            detect_rise <= 1'b0;
            detect_fall <= 1'b0;
        end else begin
            state <= nstate;
            hcnt <= nhcnt;
            detect <= ndet;
            detect_rise <= ndet && !detect;
            detect_fall <= !ndet && detect;
        end
    end
endmodule

// File: tb/tb_iir_energy_detector.sv
// tb_iir_energy_detector: table, directed and random checks against a windowed-mean model
module tb_iir_energy_detector;
    localparam int WIN = 16, ON = 256, OFF = 128, HOLD = 2;
    logic clk = 0, rst = 1, in_valid = 0;
    logic [10:0] x = '0;
    logic [9:0] mean;
    logic mean_valid, detect, detect_rise, detect_fall;
    int total = 0, bad = 0;
    int msum, mcnt, mmean, mrun;
    bit mmv, mdet, mrise, mfall;

    typedef struct {int xa; int xb; int mean;} vec_t;
    vec_t tab[7];

    iir_energy_detector #(.WIN_LOG2(4), .TH_ON(10'd256), .TH_OFF(10'd128), .HOLD(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .mean(mean),
        .mean_valid(mean_valid), .detect(detect), .detect_rise(detect_rise),
        .detect_fall(detect_fall)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] s11(input int v);
        return v[10:0];
    endfunction

    function automatic int rect(input logic [10:0] v);
        int s;
        s = int'($signed(v));
        return s < 0 ? (s == -1024 ? 1023 : -s) : s;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit v, input logic [10:0] xv);
        int m;
        bit pd;
        if (r) begin
            msum = 0; mcnt = 0; mmean = 0; mrun = 0;
            mmv = 0; mdet = 0; mrise = 0; mfall = 0;
            return;
        end
        mmv = 0; mrise = 0; mfall = 0;
        if (!v) return;
        msum += rect(xv);
        mcnt++;
        if (mcnt < WIN) return;
        m = msum / WIN;
        mmean = m; mmv = 1; msum = 0; mcnt = 0; pd = mdet;
        if (!mdet) mrun = m >= ON ? mrun + 1 : 0;
        else mrun = m < OFF ? mrun + 1 : 0;
        if (mrun == HOLD) begin mdet = !mdet; mrun = 0; end
        mrise = mdet && !pd;
        mfall = !mdet && pd;
    endtask

    task automatic cyc(input bit r, input bit v, input logic [10:0] xv);
        rst = r; in_valid = v; x = xv;
        @(posedge clk);
        #1;
        model(r, v, xv);
        chk("mean", int'(mean), mmean);
        chk("mean_valid", int'(mean_valid), int'(mmv));
        chk("detect", int'(detect), int'(mdet));
        chk("detect_rise", int'(detect_rise), int'(mrise));
        chk("detect_fall", int'(detect_fall), int'(mfall));
    endtask

    task automatic win(input int a, input int b);
        for (int i = 0; i < WIN; i++) cyc(0, 1, s11(i[0] ? b : a));
    endtask

    initial begin
        bit seen;
        tab[0] = '{300, 300, 300};
        tab[1] = '{-1024, -1024, 1023};
        tab[2] = '{1023, 1023, 1023};
        tab[3] = '{-1, -1, 1};
        tab[4] = '{0, 0, 0};
        tab[5] = '{-500, 7, 253};
        tab[6] = '{200, -200, 200};

        for (int i = 0; i < 3; i++) cyc(1, 1, s11(500));
        chk("reset_detect", int'(detect), 0);
        chk("reset_mean", int'(mean), 0);

        for (int i = 0; i < 15; i++) cyc(0, 1, s11(300));
        chk("no_early_mean_valid", int'(mean_valid), 0);
        cyc(0, 1, s11(300));
        chk("on_w1_mean", int'(mean), 300);
        chk("on_w1_mv", int'(mean_valid), 1);
        chk("on_w1_detect", int'(detect), 0);
        win(300, 300);
        chk("on_w2_detect", int'(detect), 1);
        chk("on_w2_rise", int'(detect_rise), 1);

        win(-1024, -1024);
        chk("sat_mean", int'(mean), 1023);
        win(200, -200);
        chk("alt_mean", int'(mean), 200);

        win(200, 200);
        win(200, 200);
        chk("hyst_hold", int'(detect), 1);
        win(100, 100);
        chk("off_w1_detect", int'(detect), 1);
        win(100, 100);
        chk("off_fall", int'(detect_fall), 1);
        chk("off_detect", int'(detect), 0);

        seen = 0;
        for (int i = 0; i < 2 * WIN; i++) begin
            cyc(0, 1, s11(i < WIN ? 300 : 100));
            seen |= detect | detect_rise;
        end
        chk("debounce_quiet", int'(seen), 0);
        win(300, 300);
        chk("debounce_reidle", int'(detect), 0);

        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cyc(0, i % 3 == 2, s11(400));
            seen = mean_valid;
            if (seen) chk("gap_cycles", i, 47);
        end
        chk("gap_mv_seen", int'(seen), 1);
        chk("gap_mean", int'(mean), 400);

        for (int i = 0; i < 10; i++) cyc(0, 1, s11(700));
        cyc(1, 1, s11(700));
        win(50, 50);
        chk("midrst_mean", int'(mean), 50);

        foreach (tab[i]) begin
            win(tab[i].xa, tab[i].xb);
            chk("tab_mean", int'(mean), tab[i].mean);
            chk("tab_mv", int'(mean_valid), 1);
        end

        for (int w = 0; w < 40; w++) begin
            int lvl, n;
            case ($urandom_range(0, 4))
                0: lvl = 50;
                1: lvl = 150;
                2: lvl = 250;
                3: lvl = 400;
                default: lvl = 900;
            endcase
            n = 0;
            while (n < WIN) begin
                bit v;
                int mag;
                v = $urandom_range(0, 3) != 0;
                mag = lvl - 40 + int'($urandom_range(0, 80));
                if ($urandom_range(0, 1) == 1) mag = -mag;
                if ($urandom_range(0, 49) == 0) mag = -1024;
                cyc($urandom_range(0, 599) == 0, v, s11(mag));
                if (v) n++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iir_energy_detector.md
Name: iir_energy_detector

Overview:
- Downstream consumer of the IIR band-pass section in the detector backend.
- Takes the filter's Q1.10 output stream and rectifies each sample with a saturating absolute value.
- Averages the rectified samples over fixed windows of 2^WIN_LOG2 valid samples.
- Runs a debounced hysteresis FSM on each window mean and asserts a tone-detect flag.

Parameters:
- WIN_LOG2, 4, log2 of window length in valid samples (window = 16); legal range 1..8.
- TH_ON, 256, unsigned Q0.10 mean threshold for turn-on (compare >=).
- TH_OFF, 128, unsigned Q0.10 mean threshold for turn-off (compare <); TH_OFF <= TH_ON required.
- HOLD, 2, consecutive qualifying windows needed to change detect state; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  x carries a new sample this cycle; tie high when the filter updates every clock.
- x  in  11  signed Q1.10 sample from the IIR section output.
- mean  out  10  unsigned Q0.10 mean of |x| over the last completed window.
- mean_valid  out  1  one-cycle pulse when mean updates.
- detect  out  1  tone-present flag (level).
- detect_rise  out  1  one-cycle pulse on a 0->1 transition of detect.
- detect_fall  out  1  one-cycle pulse on a 1->0 transition of detect.

Behaviour:
- Reset: all outputs 0.
  - Accumulator, sample counter and hold counter are cleared to 0.
  - FSM goes to IDLE.
  - A reset mid-window discards the partial sum.
- Rectify: a = |x|, 10-bit unsigned. x = -1024 saturates to 1023. Non-negative x passes unchanged.
- Accumulator:
  - Width 10+WIN_LOG2 bits, unsigned; it never overflows, because max = 1023*2^WIN_LOG2.
  - It updates only when in_valid=1.
  - The sample counter is WIN_LOG2 bits and wraps naturally.
- Window end: the valid sample that brings the counter from 2^WIN_LOG2-1 to 0 triggers the following on that same clock edge:
  - sum = acc + a.
  - mean <= sum >> WIN_LOG2 (truncate).
  - mean_valid <= 1 for exactly one cycle.
  - acc <= 0.
- Latency: mean/mean_valid update on the edge that samples the last valid input of the window.
- Cycles with in_valid=0 hold all accumulation state. Gaps are allowed anywhere, including mid-window.
- FSM state is evaluated only on window-end cycles, using the new mean m (the combinational sum>>WIN_LOG2). On other cycles the state holds.
  - IDLE (detect=0):
    - m >= TH_ON: if HOLD=1, go ACTIVE; else go ARMING with hcnt=1.
  - ARMING (detect=0):
    - m >= TH_ON: hcnt+1; on reaching HOLD, go ACTIVE.
    - m < TH_ON: go IDLE, hcnt=0.
  - ACTIVE (detect=1):
    - m < TH_OFF: if HOLD=1, go IDLE; else go RELEASING with hcnt=1.
  - RELEASING (detect=1):
    - m < TH_OFF: hcnt+1; on reaching HOLD, go IDLE.
    - m >= TH_OFF: go ACTIVE, hcnt=0.
- detect is registered, equal to (state is ACTIVE or RELEASING). It changes on the same edge as the mean_valid that caused the transition.
- detect_rise / detect_fall are registered and high for the cycle in which detect first shows its new value.
- Means in [TH_OFF, TH_ON) give no transition from IDLE or ACTIVE. From ARMING such a mean drops to IDLE; from RELEASING it returns to ACTIVE.

Decomposition:
- Package iir_det_pkg holds:
  - the FSM state enum {IDLE, ARMING, ACTIVE, RELEASING};
  - the sample width constant (11) and mean width constant (10);
  - the default thresholds.
- Sub-module window_accumulator holds the rectifier, accumulator, counter and the mean/mean_valid registers.
- The top level holds the FSM, hold counter and detect/edge outputs.

Test Plan:
- Reset check: assert rst for 3 cycles with x=500, in_valid=1. All outputs stay 0. No mean_valid is seen until 16 valid samples after rst drops.
- Turn-on: x=300 constant, in_valid=1.
  - Window 1 (edge 16): mean=300, mean_valid pulse, detect=0.
  - Window 2 (edge 32): detect=1 and detect_rise pulses once.
- Saturation and sign: x=-1024 for one window gives mean=1023. x alternating +200/-200 gives mean=200.
- Hysteresis turn-off: from ACTIVE, apply two windows of x=200; detect stays 1. Then two windows of x=100: detect_fall pulses at the end of the second window and detect=0.
- Debounce: from IDLE, one window of x=300 then one window of x=100 returns the FSM to IDLE. detect and detect_rise are never asserted.
- Valid gaps and mid-window reset:
  - in_valid every 3rd cycle with x=400: mean_valid occurs after 16 valid samples (about 48 cycles), mean=400.
  - rst after 10 samples, then 16 samples of x=50: mean=50, with no contribution from the pre-reset samples.
